// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch resolution, operand-hazard stall,
// 2-bit BHT prediction for IF, one-cycle redirect/flush on mispredict.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   if_pc / if_pred_taken      BHT lookup for fetch
//   id_valid, id_is_branch     ID instruction qualifiers
//   id_funct3, id_pc, id_imm   branch fields
//   id_pred_taken              prediction carried from IF
//   hz_busy                    operands not yet forwardable
//   cmp_func / cmp_taken       comparator select and result
//   stall, flush               pipeline control
//   redirect_valid/_pc         corrected fetch PC
//   branch_cnt, mispred_cnt    saturating statistics
module branch_ctrl #(
   parameter int XLEN      = 32,
   parameter int BHT_IDX_W = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  if_pc,
   output logic             if_pred_taken,
   input  logic             id_valid,
   input  logic             id_is_branch,
   input  logic [2:0]       id_funct3,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_imm,
   input  logic             id_pred_taken,
   input  logic             hz_busy,
   output logic [3:0]       cmp_func,
   input  logic             cmp_taken,
   output logic             stall,
   output logic             flush,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_REDIR
   } state_t;

   localparam int BHT_N = 2 ** BHT_IDX_W;

   state_t state, state_nx;

   logic [1:0]           bht [BHT_N];
   logic                 legal;
   logic                 resolve;
   logic                 mispred;
   logic                 stall_c;
   logic                 redir_q;
   logic [XLEN-1:0]      target;
   logic [BHT_IDX_W-1:0] rd_idx;
   logic [BHT_IDX_W-1:0] wr_idx;
   logic                 unused_ok;

   assign rd_idx    = if_pc[BHT_IDX_W+1:2];
   assign wr_idx    = id_pc[BHT_IDX_W+1:2];
   assign unused_ok = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0]};

   always_comb begin
      legal = 1'b0;
      if (id_valid && id_is_branch) begin
         case (id_funct3)
            3'b000, 3'b001,
            3'b100, 3'b101: legal = 1'b1;
            default:        legal = 1'b0;
         endcase
      end
   end

   assign cmp_func = legal ? {1'b0, id_funct3} : 4'b1111;
   assign mispred  = cmp_taken != id_pred_taken;
   assign target   = cmp_taken ? id_pc + id_imm
                               : id_pc + XLEN'(4);

   // WAIT only differs from IDLE in that it remembers a stall
   // is in progress; a branch that disappears simply drops out.
   always_comb begin
      state_nx = state;
      stall_c  = 1'b0;
      resolve  = 1'b0;
      unique case (state)
         S_IDLE, S_WAIT: begin
            state_nx = S_IDLE;
            if (legal) begin
               if (hz_busy) begin
                  stall_c  = 1'b1;
                  state_nx = S_WAIT;
               end else begin
                  resolve  = 1'b1;
                  state_nx = mispred ? S_REDIR : S_IDLE;
               end
            end
         end
         S_REDIR: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Gate with reset so stall releases the moment reset asserts.
   assign stall          = stall_c & rst_n;
   assign flush          = redir_q;
   assign redirect_valid = redir_q;
   assign if_pred_taken  = bht[rd_idx][1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         redir_q     <= 1'b0;
         redirect_pc <= '0;
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         state   <= state_nx;
         redir_q <= resolve & mispred;
         if (resolve && mispred)
            redirect_pc <= target;
         if (resolve && branch_cnt != '1)
            branch_cnt <= branch_cnt + CNT_W'(1);
         if (resolve && mispred && mispred_cnt != '1)
            mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_N; i++)
            bht[i] <= 2'b01;
      end else if (resolve) begin
         if (cmp_taken) begin
            if (bht[wr_idx] != 2'b11)
               bht[wr_idx] <= bht[wr_idx] + 2'b01;
         end else begin
            if (bht[wr_idx] != 2'b00)
               bht[wr_idx] <= bht[wr_idx] - 2'b01;
         end
      end
   end

endmodule
